// File: rtl/axi_default_slave_if.sv
// axi_default_slave_if
//   AXI4 bus bundle between the interconnect default-slave port and the
//   DECERR responder. Only the fields the responder drives or observes are
//   carried; other AW/AR sideband fields stay at the interconnect.
//   Ports (modport slave view):
//     aw_valid/aw_ready, aw_id, aw_addr, aw_len      write address
//     w_valid/w_ready, w_last, w_data, w_strb        write data
//     b_valid/b_ready, b_id, b_resp, b_user          write response
//     ar_valid/ar_ready, ar_id, ar_addr, ar_len      read address
//     r_valid/r_ready, r_id, r_data, r_resp,
//     r_last, r_user                                 read data
interface axi_default_slave_if #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_USER_WIDTH = 1
);
    logic                        aw_valid;
    logic                        aw_ready;
    logic [AXI_ID_WIDTH-1:0]     aw_id;
    logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]                  aw_len;

    logic                        w_valid;
    logic                        w_ready;
    logic                        w_last;
    logic [AXI_DATA_WIDTH-1:0]   w_data;
    logic [AXI_DATA_WIDTH/8-1:0] w_strb;

    logic                        b_valid;
    logic                        b_ready;
    logic [AXI_ID_WIDTH-1:0]     b_id;
    logic [1:0]                  b_resp;
    logic [AXI_USER_WIDTH-1:0]   b_user;

    logic                        ar_valid;
    logic                        ar_ready;
    logic [AXI_ID_WIDTH-1:0]     ar_id;
    logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]                  ar_len;

    logic                        r_valid;
    logic                        r_ready;
    logic [AXI_ID_WIDTH-1:0]     r_id;
    logic [AXI_DATA_WIDTH-1:0]   r_data;
    logic [1:0]                  r_resp;
    logic                        r_last;
    logic [AXI_USER_WIDTH-1:0]   r_user;

    modport master (
        output aw_valid, aw_id, aw_addr, aw_len,
        output w_valid, w_last, w_data, w_strb,
        output b_ready,
        output ar_valid, ar_id, ar_addr, ar_len,
        output r_ready,
        input  aw_ready, w_ready,
        input  b_valid, b_id, b_resp, b_user,
        input  ar_ready,
        input  r_valid, r_id, r_data, r_resp, r_last, r_user
    );

    modport slave (
        input  aw_valid, aw_id, aw_addr, aw_len,
        input  w_valid, w_last, w_data, w_strb,
        input  b_ready,
        input  ar_valid, ar_id, ar_addr, ar_len,
        input  r_ready,
        output aw_ready, w_ready,
        output b_valid, b_id, b_resp, b_user,
        output ar_ready,
        output r_valid, r_id, r_data, r_resp, r_last, r_user
    );
endinterface

// File: rtl/axi_default_slave.sv
// axi_default_slave
//   AXI4 default slave: swallows every burst routed to an unmapped region and
//   answers it with DECERR so no master is left hanging. Read and write
//   channels run independently, one outstanding transaction each.
//   Ports:
//     clk_i   clock
//     rst_i   synchronous active-high reset
//     bus     axi_default_slave_if.slave (AW/W/B/AR/R channels)
//   Optional error log, enabled by defining DEFAULT_SLAVE_ERRLOG_EN:
//     err_clr_i    clears the log (wins over a same-cycle capture)
//     err_addr_o   address of the first DECERR since clear (AR wins ties)
//     err_valid_o  err_addr_o holds a captured address
//     err_cnt_o    saturating count of accepted AW/AR requests
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   W_IDLE | aw_ready high, waiting for a write address
//   W_DATA | w_ready high, sinking beats until w_last
//   W_RESP | b_valid high with DECERR, waiting for b_ready
//   R_IDLE | ar_ready high, waiting for a read address
//   R_DATA | r_valid high with DECERR filler, counting down the burst
module axi_default_slave #(
    parameter int          AXI_ADDR_WIDTH = 32,
    parameter int          AXI_DATA_WIDTH = 32,
    parameter int          AXI_ID_WIDTH   = 4,
    parameter int          AXI_USER_WIDTH = 1,
    parameter logic [31:0] RDATA_PATTERN  = 32'hDEAD_BEEF
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    axi_default_slave_if.slave        bus
`ifdef DEFAULT_SLAVE_ERRLOG_EN
    ,
    input  logic                      err_clr_i,
    output logic [AXI_ADDR_WIDTH-1:0] err_addr_o,
    output logic                      err_valid_o,
    output logic [15:0]               err_cnt_o
`endif
);
    localparam logic [AXI_DATA_WIDTH-1:0] RDATA_FILL = {(AXI_DATA_WIDTH/32){RDATA_PATTERN}};
    localparam logic [1:0]                RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    w_state_t                w_state, w_state_nxt;
    r_state_t                r_state, r_state_nxt;
    logic [AXI_ID_WIDTH-1:0] b_id_q;
    logic [AXI_ID_WIDTH-1:0] r_id_q;
    logic [7:0]              cnt;
    logic                    aw_hs, ar_hs, r_hs;

    // Data, strobes and burst length on the write side never matter: the
    // burst ends on w_last only.
    logic unused_inputs;
    assign unused_inputs = ^{bus.w_data, bus.w_strb, bus.aw_len, bus.aw_addr, bus.ar_addr};

    assign aw_hs = bus.aw_valid && (w_state == W_IDLE);
    assign ar_hs = bus.ar_valid && (r_state == R_IDLE);
    assign r_hs  = bus.r_ready  && (r_state == R_DATA);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
            b_id_q  <= '0;
            r_id_q  <= '0;
            cnt     <= '0;
        end else begin
            w_state <= w_state_nxt;
            r_state <= r_state_nxt;
            if (aw_hs) begin
                b_id_q <= bus.aw_id;
            end
            if (ar_hs) begin
                r_id_q <= bus.ar_id;
                cnt    <= bus.ar_len;
            end else if (r_hs && (cnt != 8'd0)) begin
                cnt <= cnt - 8'd1;
            end
        end
    end

    // Every output is decoded from registered state only, so nothing on the
    // bus inputs can reach an output within the same cycle.
    always_comb begin
        w_state_nxt  = w_state;
        bus.aw_ready = 1'b0;
        bus.w_ready  = 1'b0;
        bus.b_valid  = 1'b0;
        bus.b_id     = b_id_q;
        bus.b_resp   = RESP_DECERR;
        bus.b_user   = '0;
        case (w_state)
            W_IDLE: begin
                bus.aw_ready = 1'b1;
                if (bus.aw_valid) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                bus.w_ready = 1'b1;
                if (bus.w_valid && bus.w_last) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                bus.b_valid = 1'b1;
                if (bus.b_ready) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_nxt  = r_state;
        bus.ar_ready = 1'b0;
        bus.r_valid  = 1'b0;
        bus.r_last   = 1'b0;
        bus.r_id     = r_id_q;
        bus.r_data   = RDATA_FILL;
        bus.r_resp   = RESP_DECERR;
        bus.r_user   = '0;
        case (r_state)
            R_IDLE: begin
                bus.ar_ready = 1'b1;
                if (bus.ar_valid) r_state_nxt = R_DATA;
            end
            R_DATA: begin
                bus.r_valid = 1'b1;
                bus.r_last  = (cnt == 8'd0);
                if (bus.r_ready && (cnt == 8'd0)) r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

`ifdef DEFAULT_SLAVE_ERRLOG_EN
    logic [AXI_ADDR_WIDTH-1:0] err_addr_q;
    logic                      err_valid_q;
    logic [15:0]               err_cnt_q;
    logic [1:0]                err_inc;
    logic [16:0]               err_sum;

    assign err_inc = {1'b0, aw_hs} + {1'b0, ar_hs};
    assign err_sum = {1'b0, err_cnt_q} + {15'd0, err_inc};

    always_ff @(posedge clk_i) begin
        if (rst_i || err_clr_i) begin
            err_addr_q  <= '0;
            err_valid_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            if (!err_valid_q && (aw_hs || ar_hs)) begin
                err_valid_q <= 1'b1;
                err_addr_q  <= ar_hs ? bus.ar_addr : bus.aw_addr;
            end
            err_cnt_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

    assign err_addr_o  = err_addr_q;
    assign err_valid_o = err_valid_q;
    assign err_cnt_o   = err_cnt_q;
`endif
endmodule

// File: tb/tb_axi_default_slave.sv
// tb_axi_default_slave
//   Directed and randomized bursts against axi_default_slave. Expected
//   responses come from the DECERR rules directly: a read of len L yields
//   L+1 beats with r_last on the final one, a write answers once after w_last.
//   Define DEFAULT_SLAVE_ERRLOG_EN to also exercise the error log.
module tb_axi_default_slave;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int UW = 1;
    localparam logic [DW-1:0] EXP_RDATA = {(DW/32){32'hDEAD_BEEF}};

    logic clk_i = 1'b0;
    logic rst_i;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk_i = ~clk_i;

    axi_default_slave_if #(
        .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW),
        .AXI_ID_WIDTH(IW), .AXI_USER_WIDTH(UW)
    ) bus ();

`ifdef DEFAULT_SLAVE_ERRLOG_EN
    logic          err_clr_i;
    logic [AW-1:0] err_addr_o;
    logic          err_valid_o;
    logic [15:0]   err_cnt_o;
`endif

    axi_default_slave #(
        .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW),
        .AXI_ID_WIDTH(IW), .AXI_USER_WIDTH(UW),
        .RDATA_PATTERN(32'hDEAD_BEEF)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus(bus)
`ifdef DEFAULT_SLAVE_ERRLOG_EN
        ,
        .err_clr_i(err_clr_i),
        .err_addr_o(err_addr_o),
        .err_valid_o(err_valid_o),
        .err_cnt_o(err_cnt_o)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land just after the edge, where outputs are settled.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // mode 0: r_ready always high; 1: random (75% high); 2: pattern 1,0,0,1
    task automatic do_read(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                           input int len, input int mode);
        int beat;
        int cyc;
        bus.ar_valid = 1'b1;
        bus.ar_id    = id;
        bus.ar_addr  = addr;
        bus.ar_len   = 8'(len);
        check("ar_ready_idle", 64'(bus.ar_ready), 64'd1);
        tick();
        bus.ar_valid = 1'b0;
        bus.ar_id    = IW'($urandom);
        bus.ar_len   = 8'($urandom);
        beat = 0;
        cyc  = 0;
        while (beat <= len && cyc < 8 * (len + 1) + 8) begin
            case (mode)
                0:       bus.r_ready = 1'b1;
                1:       bus.r_ready = ($urandom_range(0, 3) != 0);
                default: bus.r_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            endcase
            check("r_valid",        64'(bus.r_valid), 64'd1);
            check("r_last",         64'(bus.r_last),  64'(beat == len));
            check("r_id",           64'(bus.r_id),    64'(id));
            check("r_data",         64'(bus.r_data),  64'(EXP_RDATA));
            check("r_resp",         64'(bus.r_resp),  64'd3);
            check("r_user",         64'(bus.r_user),  64'd0);
            check("ar_ready_busy",  64'(bus.ar_ready), 64'd0);
            tick();
            if (bus.r_ready) beat++;
            cyc++;
        end
        bus.r_ready = 1'b0;
        check("read_beats", 64'(beat), 64'(len + 1));
        if (mode == 0) check("read_cycles", 64'(cyc), 64'(len + 1));
        check("r_valid_done",  64'(bus.r_valid),  64'd0);
        check("ar_ready_back", 64'(bus.ar_ready), 64'd1);
    endtask

    task automatic do_write(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                            input int len, input bit gaps);
        int k;
        // Data offered before the address must stall.
        bus.w_valid = 1'b1;
        bus.w_last  = 1'b1;
        check("w_ready_pre_aw", 64'(bus.w_ready), 64'd0);
        bus.aw_valid = 1'b1;
        bus.aw_id    = id;
        bus.aw_addr  = addr;
        bus.aw_len   = 8'(len);
        check("aw_ready_idle", 64'(bus.aw_ready), 64'd1);
        tick();
        bus.w_valid = 1'b0;
        bus.w_last  = 1'b0;
        bus.aw_id   = IW'($urandom);
        // aw_valid stays high during the data phase: it must not be accepted.
        for (int beat = 0; beat <= len; beat++) begin
            k = gaps ? $urandom_range(0, 2) : 0;
            repeat (k) begin
                bus.w_valid = 1'b0;
                check("w_ready_gap",   64'(bus.w_ready),  64'd1);
                check("b_valid_early", 64'(bus.b_valid),  64'd0);
                check("aw_ready_busy", 64'(bus.aw_ready), 64'd0);
                tick();
            end
            bus.w_valid = 1'b1;
            bus.w_last  = (beat == len);
            bus.w_data  = $urandom;
            bus.w_strb  = 4'($urandom);
            check("w_ready",       64'(bus.w_ready),  64'd1);
            check("aw_ready_busy", 64'(bus.aw_ready), 64'd0);
            tick();
        end
        bus.w_valid  = 1'b0;
        bus.w_last   = 1'b0;
        bus.aw_valid = 1'b0;
        check("b_valid",       64'(bus.b_valid),  64'd1);
        check("b_id",          64'(bus.b_id),     64'(id));
        check("b_resp",        64'(bus.b_resp),   64'd3);
        check("b_user",        64'(bus.b_user),   64'd0);
        check("w_ready_resp",  64'(bus.w_ready),  64'd0);
        k = gaps ? $urandom_range(0, 3) : 0;
        repeat (k) begin
            tick();
            check("b_valid_hold", 64'(bus.b_valid), 64'd1);
            check("b_id_hold",    64'(bus.b_id),    64'(id));
        end
        check("aw_ready_resp", 64'(bus.aw_ready), 64'd0);
        bus.b_ready = 1'b1;
        tick();
        bus.b_ready = 1'b0;
        check("b_valid_done",  64'(bus.b_valid),  64'd0);
        check("aw_ready_back", 64'(bus.aw_ready), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i        = 1'b1;
        bus.aw_valid = 1'b0; bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0;
        bus.w_valid  = 1'b0; bus.w_last = 1'b0; bus.w_data = '0; bus.w_strb = '0;
        bus.b_ready  = 1'b0;
        bus.ar_valid = 1'b0; bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0;
        bus.r_ready  = 1'b0;
`ifdef DEFAULT_SLAVE_ERRLOG_EN
        err_clr_i = 1'b0;
`endif
        repeat (3) tick();
        check("rst_r_valid", 64'(bus.r_valid), 64'd0);
        check("rst_b_valid", 64'(bus.b_valid), 64'd0);
        check("rst_w_ready", 64'(bus.w_ready), 64'd0);
        check("rst_r_last",  64'(bus.r_last),  64'd0);
        check("rst_b_id",    64'(bus.b_id),    64'd0);
        check("rst_r_id",    64'(bus.r_id),    64'd0);
        rst_i = 1'b0;
        tick();
        check("post_rst_aw_ready", 64'(bus.aw_ready), 64'd1);
        check("post_rst_ar_ready", 64'(bus.ar_ready), 64'd1);

        // Single write and a 4-beat read with r_ready held high.
        do_write(4'h5, 32'h2000_0000, 0, 1'b0);
        do_read(4'hA, 32'h2000_0100, 3, 0);

        // Backpressure 1,0,0,1 on a 2-beat read.
        do_read(4'h7, 32'h2000_0200, 1, 2);

        // Concurrent AW len=7 and AR len=0 accepted in the same cycle.
        bus.aw_valid = 1'b1; bus.aw_id = 4'h3; bus.aw_addr = 32'h2100_0000; bus.aw_len = 8'd7;
        bus.ar_valid = 1'b1; bus.ar_id = 4'h9; bus.ar_addr = 32'h2200_0000; bus.ar_len = 8'd0;
        check("conc_aw_ready", 64'(bus.aw_ready), 64'd1);
        check("conc_ar_ready", 64'(bus.ar_ready), 64'd1);
        tick();
        bus.aw_valid = 1'b0;
        bus.ar_valid = 1'b0;
        bus.r_ready  = 1'b1;
        for (int b = 0; b < 8; b++) begin
            bus.w_valid = 1'b1;
            bus.w_last  = (b == 7);
            check("conc_w_ready", 64'(bus.w_ready), 64'd1);
            check("conc_b_valid", 64'(bus.b_valid), 64'd0);
            if (b == 0) begin
                check("conc_r_valid", 64'(bus.r_valid), 64'd1);
                check("conc_r_last",  64'(bus.r_last),  64'd1);
                check("conc_r_id",    64'(bus.r_id),    64'h9);
            end
            if (b == 1) begin
                check("conc_r_done",   64'(bus.r_valid),  64'd0);
                check("conc_ar_ready", 64'(bus.ar_ready), 64'd1);
            end
            tick();
        end
        bus.w_valid = 1'b0;
        bus.w_last  = 1'b0;
        bus.r_ready = 1'b0;
        check("conc_b_valid_end", 64'(bus.b_valid), 64'd1);
        check("conc_b_id",        64'(bus.b_id),    64'h3);
        bus.b_ready = 1'b1;
        tick();
        bus.b_ready = 1'b0;
        check("conc_aw_back", 64'(bus.aw_ready), 64'd1);

        // Reset during beat 2 of a 6-beat read aborts it without a response.
        bus.ar_valid = 1'b1; bus.ar_id = 4'hC; bus.ar_len = 8'd5;
        tick();
        bus.ar_valid = 1'b0;
        bus.r_ready  = 1'b1;
        check("abort_beat1", 64'(bus.r_valid), 64'd1);
        tick();
        check("abort_beat2", 64'(bus.r_valid), 64'd1);
        check("abort_last2", 64'(bus.r_last),  64'd0);
        rst_i = 1'b1;
        tick();
        bus.r_ready = 1'b0;
        check("abort_r_valid", 64'(bus.r_valid), 64'd0);
        check("abort_r_last",  64'(bus.r_last),  64'd0);
        rst_i = 1'b0;
        tick();
        check("abort_ar_ready", 64'(bus.ar_ready), 64'd1);
        check("abort_r_id",     64'(bus.r_id),     64'd0);
        check("abort_r_valid2", 64'(bus.r_valid),  64'd0);
        do_read(4'h6, 32'h2300_0000, 0, 0);

        // Longest burst: 256 beats with no wrap of the beat counter.
        do_read(4'hF, 32'h2400_0000, 255, 0);

        // Randomized bursts on both channels.
        for (int i = 0; i < 20; i++) begin
            do_write(IW'($urandom), $urandom, $urandom_range(0, 7), 1'b1);
            do_read(IW'($urandom), $urandom, $urandom_range(0, 15), 1);
        end

`ifdef DEFAULT_SLAVE_ERRLOG_EN
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        check("log_clr_cnt",   64'(err_cnt_o),   64'd0);
        check("log_clr_valid", 64'(err_valid_o), 64'd0);
        do_read(4'h1, 32'h3000_0000, 0, 0);
        do_read(4'h2, 32'h4000_0000, 0, 0);
        check("log_addr",  64'(err_addr_o),  64'h3000_0000);
        check("log_cnt",   64'(err_cnt_o),   64'd2);
        check("log_valid", 64'(err_valid_o), 64'd1);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        check("log_clr2_addr",  64'(err_addr_o),  64'd0);
        check("log_clr2_cnt",   64'(err_cnt_o),   64'd0);
        check("log_clr2_valid", 64'(err_valid_o), 64'd0);
        // A clear coinciding with a handshake drops that event.
        bus.ar_valid = 1'b1; bus.ar_id = 4'h4; bus.ar_addr = 32'h5000_0000; bus.ar_len = 8'd0;
        err_clr_i = 1'b1;
        tick();
        err_clr_i    = 1'b0;
        bus.ar_valid = 1'b0;
        check("log_coinc_cnt",   64'(err_cnt_o),   64'd0);
        check("log_coinc_valid", 64'(err_valid_o), 64'd0);
        bus.r_ready = 1'b1;
        tick();
        bus.r_ready = 1'b0;
        do_read(4'h8, 32'h6000_0000, 0, 0);
        check("log_after_addr", 64'(err_addr_o), 64'h6000_0000);
        check("log_after_cnt",  64'(err_cnt_o),  64'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
